wb_rr_arbiter: RTL and testbench

- Two-master round-robin arbiter for the core's Wishbone classic bus.
- Typical masters: m0 is the sentinel core, m1 is a debug/DMA master. Both share one slave-side bus to memory and peripherals.
- A per-transfer watchdog ends any stalled transfer with err. A hung slave therefore cannot lock the core out of making progress.

---
 rtl/wb_rr_arbiter_if.sv | 18 +
 rtl/wb_rr_arbiter.sv | 109 ++++++++++
 tb/tb_wb_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone classic bundle for N masters packed side by side (master i owns slice i).
// The arbiter takes the N=2 master bundle as "slave" and drives the N=1 slave bundle as "master".
interface wb_rr_arbiter_if #(
  parameter int N = 1
);
  logic [N-1:0]    cyc;
  logic [N-1:0]    stb;
  logic [N-1:0]    we;
  logic [4*N-1:0]  sel;
  logic [30*N-1:0] adr;
  logic [32*N-1:0] dat_w;
  logic [31:0]     dat_r;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with bus lock and a per-transfer
// watchdog that aborts a stalled transfer with err so a hung slave cannot wedge the bus.
module wb_rr_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_rr_arbiter_if.slave        m,
  wb_rr_arbiter_if.master       s,
  output logic [1:0]            grant
);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

  state_t         r_state, w_state_next;
  logic           r_owner, w_owner_next;
  logic           r_last, w_last_next;
  logic [WDW-1:0] r_wdog;
  logic           w_stall, w_timeout;
  logic           w_s_cyc, w_s_stb;
  logic [1:0]     w_grant, w_ack, w_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
    end
  end

  // A stalled cycle: owner has a live strobe and the slave has not answered.
  assign w_stall = (r_state == OWNED) & m.cyc[r_owner] & m.stb[r_owner] & ~s.ack[0] & ~s.err[0];

  generate
    if (TIMEOUT == 0) begin : g_no_wdog
      assign w_timeout = 1'b0;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_wdog <= '0;
        else      r_wdog <= '0;
      end
    end else begin : g_wdog
      assign w_timeout = w_stall & (r_wdog == WDW'(TIMEOUT));
      // Saturates at TIMEOUT; any non-stalled cycle clears it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_wdog <= '0;
        else if (w_stall && r_wdog != WDW'(TIMEOUT))
          r_wdog <= r_wdog + 1'b1;
        else if (!w_stall)
          r_wdog <= '0;
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_s_cyc      = 1'b0;
    w_s_stb      = 1'b0;
    w_grant      = 2'b00;
    w_ack        = 2'b00;
    w_err        = 2'b00;
    case (r_state)
      IDLE: begin
        if (|m.cyc) begin
          w_owner_next = (&m.cyc) ? ~r_last : m.cyc[1];
          w_state_next = OWNED;
        end
      end
      OWNED: begin
        w_grant          = 2'b01 << r_owner;
        w_s_cyc          = m.cyc[r_owner];
        w_s_stb          = m.cyc[r_owner] & m.stb[r_owner];
        w_ack[r_owner]   = s.ack[0];
        w_err[r_owner]   = s.err[0];
        if (!m.cyc[r_owner]) begin
          w_last_next  = r_owner;
          w_state_next = IDLE;
        end else if (w_timeout) begin
          w_state_next = ABORT;
        end
      end
      ABORT: begin
        w_grant        = 2'b01 << r_owner;
        w_err[r_owner] = 1'b1;
        w_last_next    = r_owner;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign s.cyc   = w_s_cyc;
  assign s.stb   = w_s_stb;
  assign s.we    = m.we[r_owner];
  assign s.sel   = r_owner ? m.sel[7:4]    : m.sel[3:0];
  assign s.adr   = r_owner ? m.adr[59:30]  : m.adr[29:0];
  assign s.dat_w = r_owner ? m.dat_w[63:32] : m.dat_w[31:0];
  assign m.dat_r = s.dat_r;
  assign m.ack   = w_ack;
  assign m.err   = w_err;
  assign grant   = w_grant;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench: two Wishbone masters and a random-latency slave around the arbiter,
// a cycle-level ownership model and per-master queues of expected transfer responses.
module tb_wb_rr_arbiter;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant;

  wb_rr_arbiter_if #(.N(2)) m_bus();
  wb_rr_arbiter_if #(.N(1)) s_bus();

  wb_rr_arbiter #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .m     (m_bus.slave),
    .s     (s_bus.master),
    .grant (grant)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Reference ownership model: ms 0=free, 1=owned, 2=abort cycle.
  int ms = 0, mo = 0, ml = 1, mstall = 0;
  bit term[2];

  bit          busy[2];
  int          rem[2];
  int          gap[2];
  bit          drain = 1'b0;
  logic [29:0] c_adr[2];
  logic [31:0] c_dat[2];
  logic [3:0]  c_sel[2];
  bit          c_we[2];

  bit          pend = 1'b0;
  bit          shold = 1'b0;
  int          scnt, sdel, smode;
  logic [31:0] rdat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_drv();
    for (int i = 0; i < 2; i++) begin
      m_bus.cyc[i]            = busy[i];
      m_bus.stb[i]            = busy[i];
      m_bus.we[i]             = c_we[i];
      m_bus.sel[4*i +: 4]     = c_sel[i];
      m_bus.adr[30*i +: 30]   = c_adr[i];
      m_bus.dat_w[32*i +: 32] = c_dat[i];
    end
  endtask

  task automatic new_xfer(input int i);
    busy[i]  = 1'b1;
    c_we[i]  = 1'($urandom_range(0, 1));
    c_sel[i] = 4'($urandom_range(1, 15));
    c_adr[i] = 30'($urandom);
    c_dat[i] = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (busy[i]) begin
        if (term[i]) begin
          term[i] = 1'b0;
          if (rem[i] > 0 && !drain) begin
            rem[i]--;
            new_xfer(i);
          end else begin
            busy[i] = 1'b0;
            gap[i]  = $urandom_range(0, 3);
          end
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end else if (!drain && $urandom_range(0, 2) == 0) begin
        rem[i] = $urandom_range(0, 2);
        new_xfer(i);
      end
    end
    apply_drv();
  endtask

  // Slave: modes 0-5 short ack, 6 short err, 7 ack on the last legal wait cycle, 8 never answer.
  task automatic slave();
    exp_t e;
    s_bus.ack[0] = 1'b0;
    s_bus.err[0] = 1'b0;
    s_bus.dat_r  = $urandom;
    if (s_bus.cyc[0] && s_bus.stb[0]) begin
      if (!pend) begin
        pend  = 1'b1;
        scnt  = 0;
        smode = shold ? 8 : $urandom_range(0, 8);
        sdel  = (smode == 8) ? -1 : (smode == 7) ? TO : $urandom_range(0, 3);
        rdat  = $urandom;
        e.is_err  = (smode >= 6 && smode != 7);
        e.chk_dat = !e.is_err && !c_we[mo];
        e.dat     = rdat;
        if (mo == 0) q0.push_back(e);
        else         q1.push_back(e);
        chk("s_adr", 32'(s_bus.adr), 32'(c_adr[mo]));
        chk("s_we",  32'(s_bus.we[0]), 32'(c_we[mo]));
        chk("s_sel", 32'(s_bus.sel), 32'(c_sel[mo]));
        if (c_we[mo]) chk("s_dat_w", s_bus.dat_w, c_dat[mo]);
      end
      if (scnt == sdel) begin
        if (smode == 6) s_bus.err[0] = 1'b1;
        else begin
          s_bus.ack[0] = 1'b1;
          s_bus.dat_r  = rdat;
        end
        pend = 1'b0;
      end else begin
        scnt++;
      end
    end else begin
      pend = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 drive();
    #1 slave();
  endtask

  always @(negedge rst) begin
    ms = 0; ml = 1; mo = 0; mstall = 0;
    q0.delete();
    q1.delete();
    term[0] = 1'b0;
    term[1] = 1'b0;
  end

  always @(negedge clk) begin
    logic [1:0] eg, eack, eerr;
    logic       ecyc, estb;
    exp_t       e;
    if (!rst) begin
      chk("reset_out", 32'({grant, s_bus.cyc, s_bus.stb, m_bus.ack, m_bus.err}), 32'd0);
    end else begin
      eg = 2'b00; eack = 2'b00; eerr = 2'b00; ecyc = 1'b0; estb = 1'b0;
      if (ms == 1) begin
        eg   = (mo == 0) ? 2'b01 : 2'b10;
        ecyc = m_bus.cyc[mo];
        estb = m_bus.cyc[mo] & m_bus.stb[mo];
        eack = s_bus.ack[0] ? eg : 2'b00;
        eerr = s_bus.err[0] ? eg : 2'b00;
      end else if (ms == 2) begin
        eg   = (mo == 0) ? 2'b01 : 2'b10;
        eerr = eg;
      end
      chk("grant", 32'(grant), 32'(eg));
      chk("bus_cyc_stb_ack_err", 32'({s_bus.cyc, s_bus.stb, m_bus.ack, m_bus.err}),
          32'({ecyc, estb, eack, eerr}));
      for (int i = 0; i < 2; i++) begin
        if (m_bus.ack[i] || m_bus.err[i]) begin
          term[i] = 1'b1;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp master=%0d actual=ack%0b/err%0b required=none t=%0t",
                     i, m_bus.ack[i], m_bus.err[i], $time);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk("resp_is_err", 32'(m_bus.err[i]), 32'(e.is_err));
            if (e.chk_dat) chk("rdata", m_bus.dat_r, e.dat);
          end
        end
      end
      case (ms)
        0: if (m_bus.cyc != 2'b00) begin
             mo = (m_bus.cyc == 2'b11) ? 1 - ml : (m_bus.cyc[0] ? 0 : 1);
             ms = 1;
             mstall = 0;
           end
        1: if (!m_bus.cyc[mo]) begin
             ml = mo;
             ms = 0;
           end else if (m_bus.stb[mo] && !s_bus.ack[0] && !s_bus.err[0]) begin
             mstall++;
             if (mstall > TO) ms = 2;
           end else begin
             mstall = 0;
           end
        default: begin
          ml = mo;
          ms = 0;
        end
      endcase
    end
  end

  task automatic drain_all(input string name);
    int n;
    n = 0;
    drain = 1'b1;
    while ((busy[0] || busy[1] || q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s actual=still_busy required=idle t=%0t", name, $time);
    end
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; rem[i] = 0; gap[i] = 0;
      c_we[i] = 1'b0; c_sel[i] = 4'h0; c_adr[i] = '0; c_dat[i] = '0;
    end
    apply_drv();
    s_bus.ack[0] = 1'b0;
    s_bus.err[0] = 1'b0;
    s_bus.dat_r  = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    repeat (3000) step();
    drain_all("drain_random");

    // Kill a stalled m0 transfer with reset, then both masters contend: m0 must win.
    drain = 1'b1;
    shold = 1'b1;
    rem[0] = 0;
    new_xfer(0);
    apply_drv();
    for (int n = 0; n < 5 && !(s_bus.cyc[0] && s_bus.stb[0]); n++) step();
    chk("pre_reset_s_cyc", 32'(s_bus.cyc[0]), 32'd1);
    #1 rst = 1'b0;
    #1 chk("async_reset", 32'({grant, s_bus.cyc, s_bus.stb, m_bus.ack, m_bus.err}), 32'd0);
    shold = 1'b0;
    pend  = 1'b0;
    rem[1] = 0;
    new_xfer(1);
    apply_drv();
    @(posedge clk);
    #1 rst = 1'b1;
    drive();
    #1 slave();
    step();
    chk("post_reset_grant", 32'(grant), 32'd1);
    drain_all("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
